// File: rtl/md5_msg_pad.sv
// MD5 message padder: packs a byte-granular 32-bit word stream into padded 512-bit blocks.
// Optional MD5_PAD_BSWAP_EN: input words arrive with the first byte in [31:24] and are byte-swapped on entry.
module md5_msg_pad #(
  parameter int LEN_W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  data_i,
  input  logic [2:0]   bytes_i,
  input  logic         last_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [511:0] blk_o,
  output logic         blk_last_o,
  output logic         blk_valid_o,
  input  logic         blk_ready_i
);

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;
  localparam logic [1:0] ST_EXTRA = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [15:0][31:0] buf_q, buf_d;
  logic [3:0]        idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              pad_pending_q, pad_pending_d;
  logic              extra_q, extra_d;
  logic              blk_last_q, blk_last_d;

  logic [31:0]       word_in;
  logic [2:0]        bytes_eff;
  logic              full_beat;
  logic [LEN_W-1:0]  len_sum;
  logic [63:0]       len_sum64;
  logic [63:0]       len_cur64;
  logic [3:0]        idx_nx;
  logic [4:0]        pad_idx;

  function automatic logic [63:0] ext64(input logic [LEN_W-1:0] v);
    ext64 = '0;
    ext64[LEN_W-1:0] = v;
  endfunction

  // Keep the low valid bytes of a final word and append the 0x80 marker right after them.
  function automatic logic [31:0] pad_word(input logic [31:0] d, input logic [2:0] b);
    case (b)
      3'd0:    pad_word = 32'h0000_0080;
      3'd1:    pad_word = {16'h0000, 8'h80, d[7:0]};
      3'd2:    pad_word = {8'h00, 8'h80, d[15:0]};
      3'd3:    pad_word = {8'h80, d[23:0]};
      default: pad_word = d;
    endcase
  endfunction

`ifdef MD5_PAD_BSWAP_EN
  assign word_in = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};
`else
  assign word_in = data_i;
`endif

  assign bytes_eff = bytes_i[2] ? 3'd4 : bytes_i;
  assign full_beat = bytes_i[2];
  assign len_sum   = len_q + LEN_W'({bytes_eff, 3'b000});
  assign len_sum64 = ext64(len_sum);
  assign len_cur64 = ext64(len_q);
  assign idx_nx    = idx_q + 4'd1;
  assign pad_idx   = {1'b0, idx_q} + {4'd0, full_beat};

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    idx_d         = idx_q;
    len_d         = len_q;
    pad_pending_d = pad_pending_q;
    extra_d       = extra_q;
    blk_last_d    = blk_last_q;
    case (state_q)
      ST_RST: state_d = ST_FILL;
      ST_FILL: begin
        if (valid_i && last_i) begin
          buf_d[idx_q] = pad_word(word_in, bytes_eff);
          if (full_beat && idx_q != 4'd15) buf_d[idx_nx] = 32'h0000_0080;
          len_d   = len_sum;
          state_d = ST_EMIT;
          // Length fits in this block only if the marker landed at or before word 13.
          if (pad_idx <= 5'd13) begin
            buf_d[14]     = len_sum64[31:0];
            buf_d[15]     = len_sum64[63:32];
            blk_last_d    = 1'b1;
            extra_d       = 1'b0;
            pad_pending_d = 1'b0;
          end else begin
            blk_last_d    = 1'b0;
            extra_d       = 1'b1;
            pad_pending_d = (pad_idx == 5'd16);
          end
        end else if (valid_i && bytes_eff != 3'd0) begin
          buf_d[idx_q] = word_in;
          idx_d        = idx_nx;
          len_d        = len_sum;
          if (idx_q == 4'd15) begin
            state_d    = ST_EMIT;
            blk_last_d = 1'b0;
          end
        end
      end
      default: begin
        if (blk_ready_i) begin
          buf_d = '0;
          idx_d = 4'd0;
          if (state_q == ST_EMIT && extra_q) begin
            buf_d[0]      = pad_pending_q ? 32'h0000_0080 : 32'h0;
            buf_d[14]     = len_cur64[31:0];
            buf_d[15]     = len_cur64[63:32];
            blk_last_d    = 1'b1;
            extra_d       = 1'b0;
            pad_pending_d = 1'b0;
            state_d       = ST_EXTRA;
          end else begin
            if (blk_last_q) begin
              len_d         = '0;
              pad_pending_d = 1'b0;
            end
            blk_last_d = 1'b0;
            state_d    = ST_FILL;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_RST;
      buf_q         <= '0;
      idx_q         <= 4'd0;
      len_q         <= '0;
      pad_pending_q <= 1'b0;
      extra_q       <= 1'b0;
      blk_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      pad_pending_q <= pad_pending_d;
      extra_q       <= extra_d;
      blk_last_q    <= blk_last_d;
    end
  end

  assign ready_o     = (state_q == ST_FILL);
  assign blk_valid_o = state_q[1];
  assign blk_last_o  = blk_last_q;
  assign blk_o       = buf_q;

endmodule

// File: tb/tb_md5_msg_pad.sv
// Directed bench for md5_msg_pad: empty, "abc", 56- and 64-byte messages, stall, reset mid-fill.
module tb_md5_msg_pad;
  logic         clk = 1'b0;
  logic         rst_i;
  logic [31:0]  data_i;
  logic [2:0]   bytes_i;
  logic         last_i;
  logic         valid_i;
  logic         ready_o;
  logic [511:0] blk_o;
  logic         blk_last_o;
  logic         blk_valid_o;
  logic         blk_ready_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  md5_msg_pad #(.LEN_W(64)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .bytes_i(bytes_i), .last_i(last_i),
    .valid_i(valid_i), .ready_o(ready_o), .blk_o(blk_o), .blk_last_o(blk_last_o),
    .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i)
  );

  // Message words are written first-byte-in-[7:0]; reorder for the byte-swapped input build.
  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef MD5_PAD_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic send(input logic [31:0] w, input logic [2:0] b, input logic l);
    int n;
    n = 0;
    data_i = sw(w); bytes_i = b; last_i = l; valid_i = 1'b1;
    while (ready_o !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL send_timeout ready_o=%b required 1", ready_o);
    end
    @(posedge clk); #1;
    valid_i = 1'b0; last_i = 1'b0; bytes_i = 3'd0; data_i = 32'h0;
  endtask

  task automatic take(output logic [511:0] blk, output logic lst);
    int n;
    n = 0;
    while (blk_valid_o !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL take_timeout blk_valid_o=%b required 1", blk_valid_o);
    end
    blk = blk_o; lst = blk_last_o;
    blk_ready_i = 1'b1;
    @(posedge clk); #1;
    blk_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; bytes_i = 3'd0; data_i = 32'h0; blk_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ready_o, blk_valid_o, blk_last_o} !== 3'b000 || blk_o !== '0) begin
      bad++; $display("FAIL reset_outputs got rdy/vld/last=%b%b%b blk=%h required all 0",
                      ready_o, blk_valid_o, blk_last_o, blk_o);
    end
    rst_i = 1'b0;
    total++;
    if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_release_ready got %b required 0", ready_o); end
    @(posedge clk); #1;
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_fill_ready got %b required 1", ready_o); end
  endtask

  task automatic test_empty();
    logic [511:0] b, e;
    logic l;
    send(32'h0, 3'd0, 1'b1);
    total++;
    if (blk_valid_o !== 1'b1) begin bad++; $display("FAIL empty_latency blk_valid_o=%b required 1", blk_valid_o); end
    total++;
    if (ready_o !== 1'b0) begin bad++; $display("FAIL empty_ready_in_emit got %b required 0", ready_o); end
    take(b, l);
    e = '0; e[31:0] = 32'h0000_0080;
    total++;
    if (b !== e) begin bad++; $display("FAIL empty_block got %h required %h", b, e); end
    total++;
    if (l !== 1'b1) begin bad++; $display("FAIL empty_last got %b required 1", l); end
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("FAIL empty_handoff_ready got %b required 1", ready_o); end
  endtask

  task automatic test_abc();
    logic [511:0] b, e;
    logic l;
    send(32'hdead_beef, 3'd0, 1'b0);
    send(32'h0063_6261, 3'd3, 1'b1);
    take(b, l);
    e = '0; e[31:0] = 32'h8063_6261; e[32*14 +: 32] = 32'h18;
    total++;
    if (b !== e) begin bad++; $display("FAIL abc_block got %h required %h", b, e); end
    total++;
    if (l !== 1'b1) begin bad++; $display("FAIL abc_last got %b required 1", l); end
  endtask

  task automatic test_56_bytes();
    logic [511:0] b, e;
    logic l;
    e = '0;
    for (int k = 0; k < 14; k++) begin
      send(32'h1100_0000 + k, 3'd4, (k == 13));
      e[32*k +: 32] = 32'h1100_0000 + k;
    end
    e[32*14 +: 32] = 32'h80;
    take(b, l);
    total++;
    if (b !== e) begin bad++; $display("FAIL b56_blockA got %h required %h", b, e); end
    total++;
    if (l !== 1'b0) begin bad++; $display("FAIL b56_lastA got %b required 0", l); end
    take(b, l);
    e = '0; e[32*14 +: 32] = 32'h1C0;
    total++;
    if (b !== e) begin bad++; $display("FAIL b56_blockB got %h required %h", b, e); end
    total++;
    if (l !== 1'b1) begin bad++; $display("FAIL b56_lastB got %b required 1", l); end
  endtask

  task automatic test_64_bytes();
    logic [511:0] b, e;
    logic l;
    e = '0;
    for (int k = 0; k < 16; k++) begin
      send(32'hA500_0000 + k * 3, 3'd4, (k == 15));
      e[32*k +: 32] = 32'hA500_0000 + k * 3;
    end
    take(b, l);
    total++;
    if (b !== e) begin bad++; $display("FAIL b64_data_block got %h required %h", b, e); end
    total++;
    if (l !== 1'b0) begin bad++; $display("FAIL b64_data_last got %b required 0", l); end
    total++;
    if ({blk_valid_o, ready_o} !== 2'b10) begin
      bad++; $display("FAIL b64_extra_pending vld/rdy=%b%b required 10", blk_valid_o, ready_o);
    end
    take(b, l);
    e = '0; e[31:0] = 32'h80; e[32*14 +: 32] = 32'h200;
    total++;
    if (b !== e) begin bad++; $display("FAIL b64_pad_block got %h required %h", b, e); end
    total++;
    if (l !== 1'b1) begin bad++; $display("FAIL b64_pad_last got %b required 1", l); end
  endtask

  task automatic test_stall_and_reset();
    logic [511:0] b, e, snap;
    logic l;
    send(32'h0063_6261, 3'd3, 1'b1);
    snap = blk_o;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (blk_o !== snap || blk_valid_o !== 1'b1 || ready_o !== 1'b0) begin
        bad++; $display("FAIL stall_cycle%0d blk=%h vld=%b rdy=%b required blk=%h vld=1 rdy=0",
                        c, blk_o, blk_valid_o, ready_o, snap);
      end
    end
    take(b, l);
    send(32'h1234_5678, 3'd4, 1'b0);
    send(32'h9abc_def0, 3'd4, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    total++;
    if ({ready_o, blk_valid_o, blk_last_o} !== 3'b000 || blk_o !== '0) begin
      bad++; $display("FAIL midreset_outputs rdy/vld/last=%b%b%b blk=%h required all 0",
                      ready_o, blk_valid_o, blk_last_o, blk_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("FAIL midreset_ready got %b required 1", ready_o); end
    send(32'h0063_6261, 3'd3, 1'b1);
    take(b, l);
    e = '0; e[31:0] = 32'h8063_6261; e[32*14 +: 32] = 32'h18;
    total++;
    if (b !== e || l !== 1'b1) begin
      bad++; $display("FAIL midreset_abc got %h last=%b required %h last=1", b, l, e);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_56_bytes();
    test_64_bytes();
    test_stall_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
